// File: rtl/debounce_pkg.sv
// Shared constants for the push-button debouncer and later input stages.
package debounce_pkg;

  // Debounce FSM encoding. Bit 1 tracks the accepted level.
  localparam logic [1:0] IDLE_LOW  = 2'b00;
  localparam logic [1:0] WAIT_HIGH = 2'b01;
  localparam logic [1:0] IDLE_HIGH = 2'b11;
  localparam logic [1:0] WAIT_LOW  = 2'b10;

  typedef enum logic [1:0] {
    StIdleLow  = IDLE_LOW,
    StWaitHigh = WAIT_HIGH,
    StIdleHigh = IDLE_HIGH,
    StWaitLow  = WAIT_LOW
  } state_e;

  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_REPEAT_CYCLES = 8;
  localparam int unsigned DEF_CNT_W         = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
module sync_2ff (
  input  logic Clk,
  input  logic Clr,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s_q;

  // Shift the raw input through two flops; both clear on Clr.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      s1_q <= d_i;
      s_q  <= s1_q;
    end
  end

  assign q_o = s_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronises Btn_in, accepts a new level after STABLE_CYCLES
// consecutive matching samples and emits registered Level/Rise/Fall.
// Define BTN_REPEAT_EN to add an auto-repeat strobe while the button is held high.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic Clk,
  input  logic Clr,
  input  logic Btn_in,
  output logic Level,
  output logic Rise,
  output logic Fall,
  output logic Repeat
);

  // Reject parameter sets the counter cannot represent.
  if (STABLE_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      (64'(1) << CNT_W) <= 64'(STABLE_CYCLES) ||
      (64'(1) << CNT_W) <= 64'(REPEAT_CYCLES)) begin : g_bad_params
    $error("button_debouncer: illegal STABLE_CYCLES/REPEAT_CYCLES/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_2ff u_sync (
    .Clk (Clk),
    .Clr (Clr),
    .d_i (Btn_in),
    .q_o (s)
  );

  // Stable-count FSM: next state, counter and strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StIdleLow: begin
        if (s) begin
          state_d = StWaitHigh;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      StWaitHigh: begin
        if (!s) begin
          state_d = StIdleLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdleHigh;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdleHigh: begin
        if (!s) begin
          state_d = StWaitLow;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      StWaitLow: begin
        if (s) begin
          state_d = StIdleHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdleLow;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdleLow;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= StIdleLow;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign Level = level_q;
  assign Rise  = rise_q;
  assign Fall  = fall_q;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] RepLast = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             repeat_q, repeat_d;

  // Repeat counter runs only while staying in IDLE_HIGH; the entry cycle is count 0.
  always_comb begin
    rep_cnt_d = '0;
    repeat_d  = 1'b0;
    if (state_q == StIdleHigh && s) begin
      if (rep_cnt_q == RepLast) begin
        repeat_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  // Repeat counter and strobe flops.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      rep_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign Repeat = repeat_q;
`else
  assign Repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: behavioural model plus directed literal checks.
module tb_button_debouncer;

  localparam int unsigned S = 4;
  localparam int unsigned R = 8;
  localparam int unsigned W = 16;

  logic Clk    = 1'b0;
  logic Clr    = 1'b0;
  logic Btn_in = 1'b0;
  logic Level, Rise, Fall, Repeat;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  button_debouncer #(
    .STABLE_CYCLES (S),
    .CNT_W         (W),
    .REPEAT_CYCLES (R)
  ) dut (
    .Clk    (Clk),
    .Clr    (Clr),
    .Btn_in (Btn_in),
    .Level  (Level),
    .Rise   (Rise),
    .Fall   (Fall),
    .Repeat (Repeat)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Reference model: a level flips once the last S synchronised samples all disagree with it.
  logic m_a = 1'b0, m_b = 1'b0, ms = 1'b0;
  logic m_lvl = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_rep = 1'b0, m_in_hi = 1'b0;
  bit   mflip;
  int   m_streak = 0;
  logic m_win[$];

  always @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      m_a = 0; m_b = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_rep = 0;
      m_in_hi = 0; m_streak = 0;
      m_win.delete();
    end else begin
      ms  = m_b;
      m_b = m_a;
      m_a = Btn_in;
      m_rise = 0; m_fall = 0; m_rep = 0;
      m_win.push_back(ms);
      if (m_win.size() > S) void'(m_win.pop_front());
      mflip = (m_win.size() == S);
      foreach (m_win[i]) if (m_win[i] == m_lvl) mflip = 0;
      if (mflip) begin
        m_lvl = !m_lvl;
        if (m_lvl) m_rise = 1; else m_fall = 1;
        m_win.delete();
      end
      // Cycles spent continuously held high after acceptance or a rejected release glitch.
      if (m_rise) begin
        m_in_hi = 1; m_streak = 0;
      end else if (m_lvl && ms) begin
        m_streak = m_in_hi ? m_streak + 1 : 0;
        m_in_hi  = 1;
      end else begin
        m_in_hi = 0; m_streak = 0;
      end
`ifdef BTN_REPEAT_EN
      m_rep = m_in_hi && m_streak > 0 && (m_streak % R) == 0;
`endif
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    check("model_level", Level, m_lvl);
    check("model_rise", Rise, m_rise);
    check("model_fall", Fall, m_fall);
    check("model_repeat", Repeat, m_rep);
    check("rise_fall_excl", Rise & Fall, 1'b0);
  end

  int  cnt_r, cnt_l, len;
  bit  seen;
  logic pat[7];
  logic exp_rep;

  initial begin
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset held with button pressed.
    Btn_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("rst_hold_level", Level, 1'b0);
      check("rst_hold_rise", Rise, 1'b0);
      check("rst_hold_repeat", Repeat, 1'b0);
    end
    Clr = 1'b1;
    step(5);
    check("rst_rel_rise_early", Rise, 1'b0);
    step(1);
    check("rst_rel_rise", Rise, 1'b1);
    check("rst_rel_level", Level, 1'b1);
    step(1);
    check("rst_rel_rise_once", Rise, 1'b0);

    // Clean release.
    step(5);
    Btn_in = 1'b0;
    step(5);
    check("release_fall_early", Fall, 1'b0);
    check("release_level_held", Level, 1'b1);
    step(1);
    check("release_fall", Fall, 1'b1);
    check("release_level", Level, 1'b0);
    step(1);
    check("release_fall_once", Fall, 1'b0);

    // Bounce with high runs of at most 3 samples.
    step(6);
    cnt_r = 0; cnt_l = 0;
    for (int i = 0; i < 40; i++) begin
      Btn_in = pat[i % 7];
      step(1);
      if (Rise) cnt_r++;
      if (Level) cnt_l++;
    end
    check("bounce_no_rise", cnt_r != 0, 1'b0);
    check("bounce_level_low", cnt_l != 0, 1'b0);
    Btn_in = 1'b1;
    cnt_r = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (Rise) cnt_r++;
    end
    check("bounce_then_hold_one_rise", cnt_r == 1, 1'b1);
    check("bounce_then_hold_level", Level, 1'b1);

    // Auto-repeat while held.
    Btn_in = 1'b0;
    step(10);
    Btn_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (Rise) seen = 1;
    end
    check("repeat_rise_seen", seen, 1'b1);
    for (int j = 1; j <= 30; j++) begin
      step(1);
`ifdef BTN_REPEAT_EN
      exp_rep = (j % R) == 0;
`else
      exp_rep = 1'b0;
`endif
      check("repeat_at", Repeat, exp_rep);
      check("repeat_rise_quiet", Rise, 1'b0);
    end

    // Reset in the middle of a count.
    Btn_in = 1'b0;
    step(12);
    Btn_in = 1'b1;
    step(4);
    #2 Clr = 1'b0;
    #1;
    check("midrst_level", Level, 1'b0);
    check("midrst_rise", Rise, 1'b0);
    @(negedge Clk);
    Clr = 1'b1;
    step(5);
    check("midrst_rise_early", Rise, 1'b0);
    step(1);
    check("midrst_rise", Rise, 1'b1);
    check("midrst_level_high", Level, 1'b1);
    step(1);
    check("midrst_rise_once", Rise, 1'b0);

    // Randomised runs with occasional asynchronous resets.
    for (int r = 0; r < 300; r++) begin
      Btn_in = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 99) == 0) begin
          #3 Clr = 1'b0;
          @(negedge Clk);
          Clr = 1'b1;
        end else begin
          step(1);
        end
      end
    end

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
